// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_INCR   = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/acknowledge bus between fetch_stage and the memory.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            ImemReq;
    logic [XLEN-1:0] ImemAddr;
    logic            ImemAck;
    logic [XLEN-1:0] ImemData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemData
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load wins, then flush, then stall holds, otherwise a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            instr <= XLEN'(NOP_INSTR);
            valid <= 1'b0;
        end else if (load) begin
            pc    <= in_pc;
            instr <= in_instr;
            valid <= 1'b1;
        end else if (flush || !stall) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, request FSM and stall hold buffer feeding the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds a saturating FetchCount output.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                BranchTaken,
    input  logic [XLEN-1:0]     BranchTarget,
    fetch_stage_if.master       imem,
    output logic [XLEN-1:0]     PC,
    output logic [XLEN-1:0]     Instruction,
    output logic [6:0]          Opcode,
    output logic                Valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         FetchCount
`endif
);

    fetch_state_t    state, next_state;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_pc, hold_pc_d, hold_instr, hold_instr_d;
    logic            hold_valid, hold_valid_d;
    logic            load, ifid_flush;
    logic [XLEN-1:0] load_pc, load_instr;
    logic [XLEN-1:0] pc_next_seq;

    assign pc_next_seq   = pc_q + XLEN'(PC_INCR);
    assign imem.ImemAddr = pc_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= XLEN'(NOP_INSTR);
            hold_valid <= 1'b0;
        end else begin
            state      <= next_state;
            pc_q       <= pc_d;
            hold_pc    <= hold_pc_d;
            hold_instr <= hold_instr_d;
            hold_valid <= hold_valid_d;
        end
    end

    always_comb begin
        next_state    = state;
        pc_d          = pc_q;
        hold_pc_d     = hold_pc;
        hold_instr_d  = hold_instr;
        hold_valid_d  = hold_valid;
        load          = 1'b0;
        load_pc       = pc_q;
        load_instr    = imem.ImemData;
        ifid_flush    = Flush;
        imem.ImemReq  = (state == FETCH);

        // A redirect overrides everything, including an ack arriving this cycle.
        if (BranchTaken) begin
            pc_d         = BranchTarget & ~XLEN'(3);
            hold_valid_d = 1'b0;
            ifid_flush   = 1'b1;
            next_state   = FETCH;
        end else begin
            unique case (state)
                IDLE: begin
                    next_state = FETCH;
                    if (Flush) hold_valid_d = 1'b0;
                end
                FETCH: begin
                    if (imem.ImemAck) begin
                        pc_d = pc_next_seq;
                        if (!Stall) begin
                            load = 1'b1;
                        end else begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = imem.ImemData;
                            hold_valid_d = 1'b1;
                            next_state   = HELD;
                        end
                    end else if (Flush) begin
                        hold_valid_d = 1'b0;
                    end
                end
                HELD: begin
                    if (Flush) begin
                        hold_valid_d = 1'b0;
                        next_state   = FETCH;
                    end else if (!Stall && hold_valid) begin
                        load         = 1'b1;
                        load_pc      = hold_pc;
                        load_instr   = hold_instr;
                        hold_valid_d = 1'b0;
                        next_state   = FETCH;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .load     (load),
        .stall    (Stall),
        .flush    (ifid_flush),
        .in_pc    (load_pc),
        .in_instr (load_instr),
        .pc       (PC),
        .instr    (Instruction),
        .valid    (Valid)
    );

    assign Opcode = Instruction[6:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            fetch_cnt <= '0;
        end else if (load && (fetch_cnt != 32'hFFFF_FFFF)) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign FetchCount = fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus redirect, wrap and reset sequences.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        stall, flush, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc, instruction;
    logic [6:0]  opcode;
    logic        valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_stage_if #(.XLEN(32)) imem ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .Clock        (clock),
        .Reset_n      (reset_n),
        .Stall        (stall),
        .Flush        (flush),
        .BranchTaken  (branch_taken),
        .BranchTarget (branch_target),
        .imem         (imem.master),
        .PC           (pc),
        .Instruction  (instruction),
        .Opcode       (opcode),
        .Valid        (valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount   (fetch_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] data;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        stall         = v.stall;
        flush         = v.flush;
        branch_taken  = v.br;
        branch_target = v.tgt;
        imem.ImemAck  = v.ack;
        imem.ImemData = v.data;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        logic [31:0] exp_op;
        exp_op = {25'd0, v.exp_instr[6:0]};
        checkVal($sformatf("v%0d ImemReq", idx), {31'd0, imem.ImemReq}, {31'd0, v.exp_req});
        checkVal($sformatf("v%0d ImemAddr", idx), imem.ImemAddr, v.exp_addr);
        checkVal($sformatf("v%0d Valid", idx), {31'd0, valid}, {31'd0, v.exp_valid});
        checkVal($sformatf("v%0d PC", idx), pc, v.exp_pc);
        checkVal($sformatf("v%0d Instruction", idx), instruction, v.exp_instr);
        checkVal($sformatf("v%0d Opcode", idx), {25'd0, opcode}, exp_op);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //            stall flush br  tgt           ack   data          req   addr          vld   pc            instr
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1111_1111, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0013};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0010_0093, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0010_0093};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0020_0113, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h0020_0113};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00A0_0093, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'h0020_0113};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'h0020_0113};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'h0020_0113};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h00A0_0093};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b0, 32'h0000_0008, 32'h00A0_0093};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h103,      1'b1, 32'hBAD0_0013, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0008, 32'h00A0_0093};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0030_0193, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'h0030_0193};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0213, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104, 32'h0040_0213};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0108, 1'b0, 32'h0000_0104, 32'h0040_0213};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0050_0293, 1'b0, 32'h0000_010C, 1'b0, 32'h0000_0104, 32'h0040_0213};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_010C, 1'b0, 32'h0000_0104, 32'h0040_0213};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0060_0313, 1'b1, 32'h0000_0110, 1'b1, 32'h0000_010C, 32'h0060_0313};

        reset_n       = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem.ImemAck  = 1'b1;
        imem.ImemData = 32'h0000_0033;

        repeat (3) @(posedge clock);
        #1;
        checkVal("reset ImemReq", {31'd0, imem.ImemReq}, 32'd0);
        checkVal("reset ImemAddr", imem.ImemAddr, 32'h0);
        checkVal("reset Valid", {31'd0, valid}, 32'd0);
        checkVal("reset PC", pc, 32'h0);
        checkVal("reset Instruction", instruction, 32'h0000_0013);
`ifdef FETCH_PERF_CNT_EN
        checkVal("reset FetchCount", fetch_count, 32'd0);
`endif

        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clock);
            #1;
            checkOutput(i, vecs[i]);
            @(negedge clock);
        end
`ifdef FETCH_PERF_CNT_EN
        checkVal("table FetchCount", fetch_count, 32'd6);
`endif

        // Redirect to the top of the address space, then wrap on the next ack.
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        imem.ImemAck = 1'b0;
        @(posedge clock); #1;
        checkVal("wrap redirect ImemAddr", imem.ImemAddr, 32'hFFFF_FFFC);
        checkVal("wrap redirect Valid", {31'd0, valid}, 32'd0);
        @(negedge clock);
        branch_taken = 1'b0; imem.ImemAck = 1'b1; imem.ImemData = 32'h0070_0393;
        @(posedge clock); #1;
        checkVal("wrap ImemAddr", imem.ImemAddr, 32'h0);
        checkVal("wrap PC", pc, 32'hFFFF_FFFC);
        checkVal("wrap Valid", {31'd0, valid}, 32'd1);

        // Reset in the middle of an active fetch with ack held high.
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkVal("midreset ImemReq", {31'd0, imem.ImemReq}, 32'd0);
        checkVal("midreset ImemAddr", imem.ImemAddr, 32'h0);
        checkVal("midreset Valid", {31'd0, valid}, 32'd0);
        checkVal("midreset Instruction", instruction, 32'h0000_0013);
        @(posedge clock); #1;
        checkVal("midreset ack ignored Valid", {31'd0, valid}, 32'd0);
        checkVal("midreset ack ignored PC", pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkVal("midreset FetchCount", fetch_count, 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1; imem.ImemAck = 1'b0;
        @(posedge clock); #1;
        checkVal("rerelease ImemReq", {31'd0, imem.ImemReq}, 32'd1);
        checkVal("rerelease ImemAddr", imem.ImemAddr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter XLEN, default 32, the PC and instruction width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port Clock  in  1  rising-edge clock.
REQ-005 SHALL have port Reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port Stall  in  1  decode not ready; hold the IF/ID register and PC.
REQ-007 SHALL have port Flush  in  1  invalidate the IF/ID register and the held instruction.
REQ-008 SHALL have port BranchTaken  in  1  redirect request from the execute stage.
REQ-009 SHALL have port BranchTarget  in  XLEN  redirect address.
REQ-010 SHALL have port ImemReq  out  1  instruction memory read request.
REQ-011 SHALL have port ImemAddr  out  XLEN  fetch address, equal to pc_q.
REQ-012 SHALL have port ImemAck  in  1  ImemData valid in this cycle.
REQ-013 SHALL have port ImemData  in  XLEN  fetched instruction word.
REQ-014 SHALL have port PC  out  XLEN  PC of the instruction held in IF/ID.
REQ-015 SHALL have port Instruction  out  XLEN  IF/ID instruction.
REQ-016 SHALL have port Opcode  out  7  Instruction[6:0], driving Control.
REQ-017 SHALL have port Valid  out  1  IF/ID holds a live instruction.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH and HELD.
REQ-019 SHALL leave IDLE for FETCH on the first clock after reset deassertion, with ImemReq=0 while in IDLE.
REQ-020 In FETCH, SHALL drive ImemReq=1 and ImemAddr=pc_q.
REQ-021 In FETCH, on ImemAck with Stall=0, SHALL load IF/ID with {pc_q, ImemData}, set Valid=1 and set pc_q to pc_q+4; this is 1-cycle latency from ack to output.
REQ-022 In FETCH, on ImemAck with Stall=1, SHALL capture {pc_q, ImemData} into the hold buffer, set pc_q to pc_q+4, leave IF/ID unchanged and go to HELD.
REQ-023 In FETCH, with no ImemAck and Stall=0, SHALL set Valid=0 (bubble); with Stall=1, IF/ID SHALL be unchanged.
REQ-024 In HELD, SHALL drive ImemReq=0; when Stall=0, SHALL move the hold buffer into IF/ID with Valid=1 and return to FETCH.
REQ-025 BranchTaken SHALL take priority over Stall, Flush and ImemAck, and in the same cycle SHALL:
- set pc_q to {BranchTarget[XLEN-1:2], 2'b00};
- discard any same-cycle ack;
- clear the hold buffer;
- set Valid=0;
- set the state to FETCH.
REQ-026 Flush without BranchTaken SHALL set Valid=0 and clear the hold buffer, SHALL NOT discard a same-cycle ack, keep pc_q, and go to FETCH from HELD.
REQ-027 Simultaneous Flush and ImemAck with Stall=0 SHALL load the new instruction with Valid=1.
REQ-028 pc_q SHALL wrap modulo 2^XLEN at 32'hFFFF_FFFC + 4.
REQ-029 Opcode SHALL be combinational from the IF/ID register only.

Reset
REQ-030 While Reset_n=0, SHALL hold:
- pc_q=RESET_PC, state=IDLE;
- PC=0, Instruction=32'h0000_0013 (NOP), Valid=0;
- ImemReq=0, hold buffer empty.
REQ-031 Reset asserted mid-fetch SHALL abandon the request immediately; an ack during reset SHALL be ignored.

Configuration
REQ-032 With macro FETCH_PERF_CNT_EN defined, SHALL add output FetchCount (32 bits, reset 0), which increments once per instruction loaded into IF/ID with Valid=1, saturates at 32'hFFFF_FFFF, and is not cleared by Flush.
REQ-033 Without FETCH_PERF_CNT_EN, SHALL have no FetchCount port or counter logic.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum, NOP_INSTR=32'h0000_0013 and PC_INCR=4.
REQ-035 Sub-module if_id_reg SHALL implement the IF/ID register with load/stall/flush inputs; the FSM, PC and hold buffer SHALL stay in fetch_stage.

Verification
REQ-036 SHALL cover reset release with RESET_PC=0 and ImemAck tied 1: ImemAddr sequence 0,4,8; Valid rises 2 cycles after release; Opcode follows ImemData[6:0].
REQ-037 SHALL cover Stall=1 for 3 cycles during an ack of 32'h00A00093 at 0x8: state HELD, ImemReq=0; after Stall drops, Instruction=32'h00A00093, PC=0x8, next ImemAddr=0xC.
REQ-038 SHALL cover BranchTaken=1 with BranchTarget=0x103 together with Stall and ImemAck: next ImemAddr=0x100, Valid=0, the acked word is never output.
REQ-039 SHALL cover Flush alone while HELD: Valid=0, buffer discarded, fetch resumes at the PC after the buffered instruction.
REQ-040 SHALL cover pc_q=0xFFFFFFFC with an ack: next ImemAddr=0x0.
REQ-041 SHALL cover, with FETCH_PERF_CNT_EN, 5 accepted fetches, 1 flushed and 1 branch-discarded: FetchCount=5.
